ym2149_bus_arbiter: RTL and testbench
=====================================

// Module: ym2149_bus_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the ym2149 PSG register bus. Requesters A (CPU) and B (replay engine)
//  issue single-register read or write transactions. The block grants one of them and converts the transaction
//  into the PSG's BDIR/BC protocol: an address-latch phase, then a data-write or read phase.
//  Each BDIR pulse is separated by a low gap so the PSG's rising-edge detector re-arms.
// PARAMETERS
//  HOLD_CYC  1  cycles BDIR held high per phase (>=1)
//  GAP_CYC   1  cycles BDIR held low after each phase (>=1)
// PORTS
//  CLK        in   1  system clock, all logic on posedge
//  RESET_N    in   1  asynchronous active-low reset
//  A_REQ      in   1  requester A transaction request; hold until A_ACK
//  A_WE       in   1  1=write, 0=read; stable while A_REQ
//  A_ADDR     in   4  PSG register index
//  A_WDATA    in   8  write data
//  A_ACK      out  1  one-cycle completion pulse
//  A_RDATA    out  8  read data, valid in A_ACK cycle, held until next A read
//  B_*        --  --  identical set for requester B
//  PSG_BDIR   out  1  to ym2149 BDIR
//  PSG_BC     out  1  to ym2149 BC
//  PSG_DI     out  8  to ym2149 DI
//  PSG_DO     in   8  from ym2149 DO
//  BUSY       out  1  high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset: async, active-low. All outputs are 0: BDIR, BC, DI, ACKs, RDATAs, BUSY. FSM=IDLE. Grant pointer=A.
//  FSM: IDLE -> ADDR -> GAP1 -> (WE ? DATA -> GAP2 : RD) -> DONE -> IDLE.
//   IDLE: if any REQ is sampled, latch the winner's WE/ADDR/WDATA and go to ADDR.
//     Latching at grant means later changes to the requester's fields are ignored.
//   ADDR: BDIR=1, BC=1, DI={4'h0,addr} for HOLD_CYC cycles.
//   GAP1/GAP2: BDIR=0, BC=0 for GAP_CYC cycles. DI holds its last value.
//   DATA: BDIR=1, BC=0, DI=wdata for HOLD_CYC cycles.
//   RD: BDIR=0, BC=1 for 1 cycle. PSG_DO is captured into the winner's RDATA at the exit edge.
//   DONE: 1 cycle; winner's ACK=1, the other ACK=0. The next edge returns to IDLE.
//   IDLE takes one cycle, so back-to-back transactions have a minimum 1-cycle BDIR-low idle on top of the gap.
//  Phase counter: width $clog2(max(HOLD_CYC,GAP_CYC)+1); reloads on every phase entry, never wraps.
//  Latency, counted in edges from the grant edge to the edge that enters DONE:
//   write = 2*(HOLD_CYC+GAP_CYC); read = HOLD_CYC+GAP_CYC+1.
//  Requester rules:
//   - REQ may deassert the cycle after ACK.
//   - A REQ still high in the cycle after ACK is a new transaction.
//   - Dropping REQ before ACK does not abort the transaction; it completes and ACK still pulses.
//  Arbitration in IDLE (default): fixed priority, A beats B when both are requesting.
//  Reset mid-transaction: outputs go to 0 asynchronously and the transaction is lost with no ACK.
//   After release the FSM is in IDLE.
//  BDIR never rises in two consecutive cycles without an intervening low (guaranteed by GAP_CYC>=1).
// CONFIGURATION
//  YMSEQ_RR_EN defined: round-robin arbitration.
//   - 1-bit last-grant pointer, updated at each grant.
//   - On a simultaneous request, the port not granted last wins.
//   - A lone request is always granted.
//  YMSEQ_RR_EN undefined: fixed priority A>B. No pointer register.
// TESTING
//  1 Reset: RESET_N=0 mid-stream -> immediately BDIR=BC=0, DI=0x00, ACKs=0, BUSY=0.
//  2 A write reg7=0x38, defaults -> BDIR/BC = 11,00,10,00; DI=0x07 then 0x38.
//    A_ACK one cycle, entered 4 edges after grant. PSG model reg7==0x38.
//  3 B read reg14, model IOA_in=0x5A, reg7[6]=0 -> BDIR/BC = 11,00,01.
//    B_RDATA=0x5A with B_ACK, entered 3 edges after grant.
//  4 A and B request in the same cycle -> A is served, then B (2 transactions, each with its own ACK).
//    With YMSEQ_RR_EN and last grant=A -> B first, then A.
//  5 RESET_N low during DATA phase -> no ACK and PSG reg unchanged.
//    After release, a new A write reg8=0x0F completes normally.
//  6 HOLD_CYC=3, GAP_CYC=2, A write -> BDIR high 3 cycles per phase and low 2 cycles; ACK entered 10 edges after grant.

Source files
------------

// File: rtl/ym2149_bus_arbiter.sv
// ym2149_bus_arbiter: two-port arbiter/sequencer driving the YM2149 BDIR/BC bus.
// Ports: CLK, RESET_N (async low); A_*/B_* request ports (REQ, WE, ADDR, WDATA,
// ACK, RDATA); PSG_BDIR, PSG_BC, PSG_DI, PSG_DO; BUSY.
// Option: define YMSEQ_RR_EN for round-robin arbitration (default: A beats B).
module ym2149_bus_arbiter #(
    parameter int HOLD_CYC = 1,
    parameter int GAP_CYC  = 1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       A_REQ,
    input  logic       A_WE,
    input  logic [3:0] A_ADDR,
    input  logic [7:0] A_WDATA,
    output logic       A_ACK,
    output logic [7:0] A_RDATA,
    input  logic       B_REQ,
    input  logic       B_WE,
    input  logic [3:0] B_ADDR,
    input  logic [7:0] B_WDATA,
    output logic       B_ACK,
    output logic [7:0] B_RDATA,
    output logic       PSG_BDIR,
    output logic       PSG_BC,
    output logic [7:0] PSG_DI,
    input  logic [7:0] PSG_DO,
    output logic       BUSY
);

    localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP1, S_DATA, S_GAP2, S_RD, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, win_q;
    logic [3:0]    addr_q;
    logic [7:0]    wd_q, di_q, a_rd_q, b_rd_q;
    logic          grant, gnt_b, ph_done, to_data;

`ifdef YMSEQ_RR_EN
    // last_q: 0 = A granted last, 1 = B granted last
    logic last_q;
    assign gnt_b = B_REQ && (!A_REQ || !last_q);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)   last_q <= 1'b0;
        else if (grant) last_q <= gnt_b;
    end
`else
    assign gnt_b = !A_REQ;
`endif

    assign ph_done = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        to_data = 1'b0;
        // counter only moves while non-zero, so it never wraps
        if (!ph_done) cnt_d = cnt_q - CW'(1);
        case (state_q)
            S_IDLE: if (A_REQ || B_REQ) begin
                grant   = 1'b1;
                state_d = S_ADDR;
                cnt_d   = HOLD_LD;
            end
            S_ADDR: if (ph_done) begin
                state_d = S_GAP1;
                cnt_d   = GAP_LD;
            end
            S_GAP1: if (ph_done) begin
                if (we_q) begin
                    to_data = 1'b1;
                    state_d = S_DATA;
                    cnt_d   = HOLD_LD;
                end else begin
                    state_d = S_RD;
                    cnt_d   = '0;
                end
            end
            S_DATA: if (ph_done) begin
                state_d = S_GAP2;
                cnt_d   = GAP_LD;
            end
            S_GAP2: if (ph_done) state_d = S_DONE;
            S_RD:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            win_q   <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            di_q    <= '0;
            a_rd_q  <= '0;
            b_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                win_q  <= gnt_b;
                we_q   <= gnt_b ? B_WE    : A_WE;
                addr_q <= gnt_b ? B_ADDR  : A_ADDR;
                wd_q   <= gnt_b ? B_WDATA : A_WDATA;
                di_q   <= {4'h0, gnt_b ? B_ADDR : A_ADDR};
            end
            // DI keeps its value through gaps and idle
            if (to_data) di_q <= wd_q;
            if (state_q == S_RD) begin
                if (win_q) b_rd_q <= PSG_DO;
                else       a_rd_q <= PSG_DO;
            end
        end
    end

    always_comb begin
        PSG_BDIR = 1'b0;
        PSG_BC   = 1'b0;
        case (state_q)
            S_ADDR: begin
                PSG_BDIR = 1'b1;
                PSG_BC   = 1'b1;
            end
            S_DATA: PSG_BDIR = 1'b1;
            S_RD:   PSG_BC   = 1'b1;
            default: ;
        endcase
    end

    assign PSG_DI  = di_q;
    assign A_ACK   = (state_q == S_DONE) && !win_q;
    assign B_ACK   = (state_q == S_DONE) && win_q;
    assign A_RDATA = a_rd_q;
    assign B_RDATA = b_rd_q;
    assign BUSY    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ym2149_bus_arbiter.sv
// tb_ym2149_bus_arbiter: directed vectors plus multi-cycle sequences for
// the YM2149 bus arbiter, with a small PSG register model on each bus.
module tb_ym2149_bus_arbiter;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [3:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_wd = 0, b_wd = 0;
    logic       a_ack, b_ack, bdir, bc, busy;
    logic [7:0] a_rd, b_rd, di, do_;

    logic       h_req = 0, h_we = 0;
    logic [3:0] h_addr = 0;
    logic [7:0] h_wd = 0;
    logic       h_ack, hb_ack, h_bdir, h_bc, h_busy;
    logic [7:0] h_rd, hb_rd, h_di, h_do;
    logic       hb_req = 0, hb_we = 0;
    logic [3:0] hb_addr = 0;
    logic [7:0] hb_wd = 0;

    ym2149_bus_arbiter u_dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wd),
        .A_ACK(a_ack), .A_RDATA(a_rd),
        .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wd),
        .B_ACK(b_ack), .B_RDATA(b_rd),
        .PSG_BDIR(bdir), .PSG_BC(bc), .PSG_DI(di), .PSG_DO(do_),
        .BUSY(busy)
    );

    ym2149_bus_arbiter #(.HOLD_CYC(3), .GAP_CYC(2)) u_slow (
        .CLK(CLK), .RESET_N(RESET_N),
        .A_REQ(h_req), .A_WE(h_we), .A_ADDR(h_addr), .A_WDATA(h_wd),
        .A_ACK(h_ack), .A_RDATA(h_rd),
        .B_REQ(hb_req), .B_WE(hb_we), .B_ADDR(hb_addr), .B_WDATA(hb_wd),
        .B_ACK(hb_ack), .B_RDATA(hb_rd),
        .PSG_BDIR(h_bdir), .PSG_BC(h_bc), .PSG_DI(h_di), .PSG_DO(h_do),
        .BUSY(h_busy)
    );

    // PSG models: bus sampled mid-cycle
    logic       psg_clr = 1'b1;
    logic [7:0] regs [16];
    logic [7:0] regs2 [16];
    logic [3:0] lat_addr, lat_addr2;
    logic [7:0] ioa_in;
    assign ioa_in = 8'h5A;

    always @(negedge CLK) begin
        if (psg_clr) begin
            for (int k = 0; k < 16; k++) regs[k] <= 8'h00;
            lat_addr <= 4'h0;
        end else if (bdir && bc) lat_addr <= di[3:0];
        else if (bdir && !bc)    regs[lat_addr] <= di;
    end

    always @(negedge CLK) begin
        if (psg_clr) begin
            for (int k = 0; k < 16; k++) regs2[k] <= 8'h00;
            lat_addr2 <= 4'h0;
        end else if (h_bdir && h_bc) lat_addr2 <= h_di[3:0];
        else if (h_bdir && !h_bc)    regs2[lat_addr2] <= h_di;
    end

    assign do_  = (lat_addr == 4'd14 && !regs[7][6]) ? ioa_in : regs[lat_addr];
    assign h_do = regs2[lat_addr2];

    int n_run  = 0;
    int n_fail = 0;
    bit tb_last = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic txn(input bit pb, input bit we, input logic [3:0] ad,
                       input logic [7:0] wd, output int lat,
                       output logic [11:0] seq, output logic [7:0] di_a,
                       output logic [7:0] di_d, output logic [7:0] rd,
                       output int ackw, output bit other);
        int n;
        lat = 0; seq = '0; di_a = '0; di_d = '0; rd = '0;
        ackw = 0; other = 0;
        @(negedge CLK);
        if (pb) begin
            b_req = 1; b_we = we; b_addr = ad; b_wd = wd;
        end else begin
            a_req = 1; a_we = we; a_addr = ad; a_wd = wd;
        end
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!busy && n < 50);
        tb_last = pb;
        // fields are latched at grant; scrambling must not matter
        if (pb) begin b_addr = ~ad; b_wd = ~wd; end
        else    begin a_addr = ~ad; a_wd = ~wd; end
        while (!(pb ? b_ack : a_ack) && lat < 50) begin
            if (pb ? a_ack : b_ack) other = 1;
            if (bdir) begin
                if (bc) di_a = di;
                else    di_d = di;
            end
            seq = {seq[9:0], bdir, bc};
            @(negedge CLK);
            lat++;
        end
        rd = pb ? b_rd : a_rd;
        if (pb) b_req = 0;
        else    a_req = 0;
        if (pb ? b_ack : a_ack) ackw = 1;
        if (pb ? a_ack : b_ack) other = 1;
        @(negedge CLK);
        if (pb ? b_ack : a_ack) ackw++;
    endtask

    typedef struct {
        bit         pb;
        bit         we;
        logic [3:0] ad;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int         lat, ackw;
        logic [11:0] seq;
        logic [7:0] dia, did, rd;
        bit         other;

        vecs[0] = '{0, 1, 4'd7,  8'h38, 8'h38};
        vecs[1] = '{1, 0, 4'd14, 8'h00, 8'h5A};
        vecs[2] = '{1, 1, 4'd3,  8'hA5, 8'hA5};
        vecs[3] = '{0, 0, 4'd3,  8'h00, 8'hA5};
        vecs[4] = '{0, 1, 4'd0,  8'hFF, 8'hFF};
        vecs[5] = '{1, 0, 4'd0,  8'h00, 8'hFF};
        vecs[6] = '{0, 0, 4'd14, 8'h00, 8'h5A};

        repeat (3) @(negedge CLK);
        chk("rst_outs", {bdir, bc, di, a_ack, b_ack, busy, a_rd, b_rd}, '0);
        psg_clr = 0;
        RESET_N = 1;
        @(negedge CLK);
        chk("rst_idle", {bdir, bc, di, busy}, '0);

        for (int i = 0; i < 7; i++) begin
            txn(vecs[i].pb, vecs[i].we, vecs[i].ad, vecs[i].wd,
                lat, seq, dia, did, rd, ackw, other);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].we ? 4 : 3);
            chk($sformatf("v%0d_seq", i), seq,
                vecs[i].we ? 12'h0C8 : 12'h031);
            chk($sformatf("v%0d_di_addr", i), dia, {4'h0, vecs[i].ad});
            if (vecs[i].we) begin
                chk($sformatf("v%0d_di_data", i), did, vecs[i].wd);
                chk($sformatf("v%0d_reg", i), regs[vecs[i].ad], vecs[i].exp);
            end else begin
                chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp);
            end
            chk($sformatf("v%0d_ackw", i), ackw, 1);
            chk($sformatf("v%0d_other_ack", i), other, 0);
        end

        // simultaneous requests
        begin
            bit first_b, a_seen, b_seen, exp_first;
            int na, nb, n;
            a_seen = 0; b_seen = 0; na = 0; nb = 0; n = 0; first_b = 0;
`ifdef YMSEQ_RR_EN
            exp_first = !tb_last;
`else
            exp_first = 1'b0;
`endif
            @(negedge CLK);
            a_req = 1; a_we = 1; a_addr = 4'd1; a_wd = 8'h11;
            b_req = 1; b_we = 1; b_addr = 4'd2; b_wd = 8'h22;
            while (!(a_seen && b_seen) && n < 60) begin
                @(negedge CLK);
                n++;
                if (a_ack) begin
                    na++;
                    if (!a_seen && !b_seen) first_b = 0;
                    a_seen = 1; a_req = 0;
                end
                if (b_ack) begin
                    nb++;
                    if (!a_seen && !b_seen) first_b = 1;
                    b_seen = 1; b_req = 0;
                end
            end
            repeat (2) @(negedge CLK);
            chk("arb_first", first_b, exp_first);
            chk("arb_a_acks", na, 1);
            chk("arb_b_acks", nb, 1);
            chk("arb_reg1", regs[1], 8'h11);
            chk("arb_reg2", regs[2], 8'h22);
        end

        // reset during the data phase
        begin
            int n;
            bit saw_ack;
            n = 0; saw_ack = 0;
            @(negedge CLK);
            a_req = 1; a_we = 1; a_addr = 4'd8; a_wd = 8'h55;
            do begin
                @(negedge CLK);
                n++;
            end while (!(bdir && bc) && n < 50);
            @(negedge CLK);
            @(posedge CLK);
            #1;
            chk("mid_in_data", {bdir, bc}, 2'b10);
            RESET_N = 0;
            #1;
            chk("mid_rst_outs",
                {bdir, bc, di, a_ack, b_ack, busy, a_rd, b_rd}, '0);
            a_req = 0;
            repeat (3) begin
                @(negedge CLK);
                if (a_ack || b_ack) saw_ack = 1;
            end
            RESET_N = 1;
            tb_last = 0;
            repeat (2) begin
                @(negedge CLK);
                if (a_ack || b_ack) saw_ack = 1;
            end
            chk("mid_no_ack", saw_ack, 0);
            chk("mid_reg8_kept", regs[8], 8'h00);
            chk("mid_busy", busy, 0);
            txn(0, 1, 4'd8, 8'h0F, lat, seq, dia, did, rd, ackw, other);
            chk("post_lat", lat, 4);
            chk("post_reg8", regs[8], 8'h0F);
            chk("post_ackw", ackw, 1);
        end

        // HOLD_CYC=3, GAP_CYC=2 instance
        begin
            int n, i;
            logic [15:0] pat;
            n = 0; i = 0; pat = '0;
            @(negedge CLK);
            h_req = 1; h_we = 1; h_addr = 4'd5; h_wd = 8'h12;
            do begin
                @(negedge CLK);
                n++;
            end while (!h_busy && n < 50);
            while (!h_ack && i < 50) begin
                pat = {pat[14:0], h_bdir};
                @(negedge CLK);
                i++;
            end
            h_req = 0;
            @(negedge CLK);
            chk("slow_lat", i, 10);
            chk("slow_bdir_pat", pat, 16'h039C);
            chk("slow_reg5", regs2[5], 8'h12);
            chk("slow_ack_gone", h_ack, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
